// File: rtl/piezo_arb.sv
// rtl/piezo_arb.sv - priority arbiter granting one piezo tune player at a time
// Latches request pulses, plays the highest one, enforces a silent gap and a play watchdog.
module piezo_arb #(
    parameter int GAP_CYC     = 2500000,
    parameter int TIMEOUT_CYC = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       play_done,
    output logic       play_go,
    output logic [1:0] play_sel,
    output logic       play_abort,
    output logic       piezo_en,
    output logic [2:0] pending,
    output logic       busy,
    output logic       timeout_err
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GO    = 3'd1,
        S_PLAY  = 3'd2,
        S_ABORT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      pending_q, pending_d;
    logic [1:0]      sel_q, sel_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            terr_q, terr_d;

    logic [1:0]      top_sel;
    logic [2:0]      pending_clr;
    logic            wd_expired;
    logic            preempt;

    assign top_sel    = pending_q[2] ? 2'd2 : (pending_q[1] ? 2'd1 : 2'd0);
    assign wd_expired = (wd_q == WD_LAST);
    // Only the alarm may cut a tune short, and never another alarm.
    assign preempt    = pending_q[2] && !sel_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 3'b000;
            sel_q     <= 2'b11;
            gap_q     <= '0;
            wd_q      <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pending_q != 3'b000) state_d = S_GO;
            S_GO:    state_d = S_PLAY;
            S_PLAY: begin
                if (play_done)       state_d = S_GAP;
                else if (wd_expired) state_d = S_ABORT;
                else if (preempt)    state_d = S_ABORT;
            end
            S_ABORT: state_d = S_GAP;
            S_GAP:   if (gap_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_clr = 3'b000;
        if (state_q == S_GO) pending_clr = 3'b001 << sel_q;
        // A new request in the clearing cycle survives the clear.
        pending_d = (pending_q & ~pending_clr) | req;

        sel_d = sel_q;
        if (state_q == S_IDLE) sel_d = (pending_q != 3'b000) ? top_sel : 2'b11;

        gap_d = '0;
        if (state_q == S_GAP && gap_q != GAP_LAST) gap_d = gap_q + 1'b1;

        wd_d = wd_q;
        if (state_q == S_GO)   wd_d = '0;
        if (state_q == S_PLAY) wd_d = wd_q + 1'b1;

        terr_d = terr_q | (state_q == S_PLAY && !play_done && wd_expired);
    end

    always_comb begin
        play_go     = (state_q == S_GO);
        play_abort  = (state_q == S_ABORT);
        piezo_en    = (state_q == S_PLAY);
        busy        = (state_q != S_IDLE);
        play_sel    = (state_q == S_GO || state_q == S_PLAY || state_q == S_ABORT) ? sel_q : 2'b11;
        pending     = pending_q;
        timeout_err = terr_q;
    end

endmodule

// File: tb/tb_piezo_arb.sv
// tb/tb_piezo_arb.sv - scoreboard bench for piezo_arb
// Stimulus pushes expected go/abort events with their cycle; a monitor pops and compares.
module tb_piezo_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       play_done = 1'b0;
    logic       play_go;
    logic [1:0] play_sel;
    logic       play_abort;
    logic       piezo_en;
    logic [2:0] pending;
    logic       busy;
    logic       timeout_err;

    piezo_arb #(.GAP_CYC(4), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .req(req), .play_done(play_done),
        .play_go(play_go), .play_sel(play_sel), .play_abort(play_abort),
        .piezo_en(piezo_en), .pending(pending), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_abort;
        logic [1:0] sel;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic expect_ev(input bit ab, input logic [1:0] s, input int at);
        ev_t x;
        x.is_abort = ab;
        x.sel = s;
        x.at = at;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [2:0] r, input logic d, input int c);
        at_cyc(c);
        req = r;
        play_done = d;
        @(posedge clk);
        #1;
        req = 3'b000;
        play_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (play_go === 1'b1 || play_abort === 1'b1)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got go=%0b abort=%0b sel=%0d at cyc %0d, required no event",
                         play_go, play_abort, play_sel, cyc);
            end else begin
                e = exp_q.pop_front();
                if (play_abort !== e.is_abort || play_go !== !e.is_abort ||
                    play_sel !== e.sel || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL event: got go=%0b abort=%0b sel=%0d cyc=%0d, required abort=%0b sel=%0d cyc=%0d",
                             play_go, play_abort, play_sel, cyc, e.is_abort, e.sel, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int c;
        int d1;
        int d2;
        int p;
        int q;
        int m;
        int k;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel",   {6'b0, play_sel}, 8'h03);
        chk("reset_flags", {3'b0, play_go, play_abort, piezo_en, busy, timeout_err}, 8'h00);
        chk("reset_pend",  {5'b0, pending}, 8'h00);
        rst = 1'b0;

        // single fanfare request
        c = cyc + 1;
        expect_ev(1'b0, 2'd1, c + 2);
        pulse(3'b010, 1'b0, c);
        chk("a_pend_set", {5'b0, pending}, 8'h02);
        at_cyc(c + 3);
        chk("a_play", {5'b0, piezo_en, play_sel}, 8'h05);
        chk("a_pend_clr", {5'b0, pending}, 8'h00);
        pulse(3'b000, 1'b1, c + 6);
        at_cyc(c + 14);
        chk("a_idle", {7'b0, busy}, 8'h00);

        // all three at once: order 2,1,0
        c = cyc + 1;
        expect_ev(1'b0, 2'd2, c + 2);
        pulse(3'b111, 1'b0, c);
        chk("b_pend_111", {5'b0, pending}, 8'h07);
        at_cyc(c + 3);
        chk("b_pend_011", {5'b0, pending}, 8'h03);
        d1 = c + 5;
        expect_ev(1'b0, 2'd1, d1 + 6);
        pulse(3'b000, 1'b1, d1);
        at_cyc(d1 + 2);
        chk("b_gap_out", {5'b0, piezo_en, play_sel}, 8'h03);
        at_cyc(d1 + 7);
        chk("b_pend_001", {5'b0, pending}, 8'h01);
        d2 = d1 + 10;
        expect_ev(1'b0, 2'd0, d2 + 6);
        pulse(3'b000, 1'b1, d2);
        at_cyc(d2 + 7);
        chk("b_pend_000", {5'b0, pending}, 8'h00);

        // alarm preempts chirp; chirp not replayed
        p = d2 + 9;
        expect_ev(1'b1, 2'd0, p + 2);
        expect_ev(1'b0, 2'd2, p + 8);
        pulse(3'b100, 1'b0, p);
        at_cyc(p + 3);
        chk("c_gap_out", {5'b0, piezo_en, play_sel}, 8'h03);
        q = p + 11;
        pulse(3'b000, 1'b1, q);
        at_cyc(q + 15);
        chk("c_no_replay", {4'b0, busy, pending}, 8'h00);
        pulse(3'b000, 1'b1, q + 16);
        at_cyc(q + 20);
        chk("c_done_idle", {7'b0, busy}, 8'h00);

        // watchdog abort
        c = cyc + 1;
        expect_ev(1'b0, 2'd1, c + 2);
        expect_ev(1'b1, 2'd1, c + 103);
        pulse(3'b010, 1'b0, c);
        at_cyc(c + 50);
        chk("d_terr_pre", {7'b0, timeout_err}, 8'h00);
        at_cyc(c + 104);
        chk("d_terr_set", {7'b0, timeout_err}, 8'h01);
        at_cyc(c + 120);
        chk("d_terr_sticky", {6'b0, busy, timeout_err}, 8'h01);

        // play_done and alarm in the same cycle
        c = cyc + 1;
        expect_ev(1'b0, 2'd0, c + 2);
        pulse(3'b001, 1'b0, c);
        m = c + 5;
        expect_ev(1'b0, 2'd2, m + 6);
        pulse(3'b100, 1'b1, m);
        pulse(3'b000, 1'b1, m + 9);
        at_cyc(m + 17);

        // fanfare does not preempt chirp; async reset mid-play
        c = cyc + 1;
        expect_ev(1'b0, 2'd0, c + 2);
        pulse(3'b001, 1'b0, c);
        pulse(3'b010, 1'b0, c + 4);
        at_cyc(c + 8);
        chk("f_no_preempt", {2'b0, pending, piezo_en, play_sel}, 8'h14);
        #2;
        rst = 1'b1;
        #1;
        chk("f_rst_sel", {6'b0, play_sel}, 8'h03);
        chk("f_rst_flags", {3'b0, play_go, play_abort, piezo_en, busy, timeout_err}, 8'h00);
        chk("f_rst_pend", {5'b0, pending}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // request on the first edge after reset release
        k = cyc;
        expect_ev(1'b0, 2'd2, k + 2);
        pulse(3'b100, 1'b0, k);
        pulse(3'b000, 1'b1, k + 5);
        at_cyc(k + 15);
        chk("g_idle", {4'b0, busy, pending}, 8'h00);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d events outstanding, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
